// File: rtl/bpsk_pkg.sv
// Shared definitions for the BPSK receive path: default geometry, derived widths,
// FSM encoding and the offset-binary to two's-complement conversion.
package bpsk_pkg;

    localparam int DEF_SAMPLE_NUMBER = 256;
    localparam int DEF_SAMPLE_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH    = 12;

    localparam int PHASE_W = $clog2(DEF_SAMPLE_NUMBER);
    localparam int ACC_W   = DEF_SAMPLE_WIDTH + PHASE_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Subtracting midscale is the same as inverting the MSB of a width-bit code.
    function automatic logic signed [31:0] ob_to_signed(input logic [31:0] raw,
                                                        input int          width);
        logic signed [31:0] mid;
        mid = 32'sd1 <<< (width - 1);
        return $signed(raw) - mid;
    endfunction

endpackage

// File: rtl/bpsk_correlator.sv
// Integrate-and-dump against the sign of the reference sine over one carrier period.
// Outputs are combinational: sum/dump describe the sample being accepted this cycle.
module bpsk_correlator
    import bpsk_pkg::*;
#(
    parameter  int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter  int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    localparam int PHASE_BITS    = $clog2(SAMPLE_NUMBER),
    localparam int ACC_BITS      = SAMPLE_WIDTH + PHASE_BITS
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       accept,
    input  logic                       restart,
    input  logic [SAMPLE_WIDTH-1:0]    sample,
    output logic                       dump,
    output logic signed [ACC_BITS-1:0] sum
);

    logic [PHASE_BITS-1:0]      phase_reg;
    logic [PHASE_BITS-1:0]      phase_cur;
    logic signed [ACC_BITS-1:0] acc_reg;
    logic signed [ACC_BITS-1:0] s_ext;
    logic signed [ACC_BITS-1:0] term;

    assign s_ext = ACC_BITS'(ob_to_signed(32'(sample), SAMPLE_WIDTH));

    // Reference is +1 over the first half period, so the phase MSB selects the sign.
    always_comb begin
        phase_cur = restart ? '0 : phase_reg;
        term      = phase_cur[PHASE_BITS-1] ? -s_ext : s_ext;
        sum       = (phase_cur == '0) ? term : acc_reg + term;
        dump      = accept && (phase_cur == '1);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            phase_reg <= '0;
            acc_reg   <= '0;
        end else if (accept) begin
            phase_reg <= phase_cur + 1'b1;
            acc_reg   <= sum;
        end
    end

endmodule

// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: correlator, bit decision and MSB-first word packing.
// Optional BPSK_DEMOD_SOFT_EN exposes the signed correlation sum of each decided bit.
module bpsk_demod
    import bpsk_pkg::*;
#(
    parameter  int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
    parameter  int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
    localparam int ACC_BITS      = SAMPLE_WIDTH + $clog2(SAMPLE_NUMBER)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic                    align,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic                    busy
`ifdef BPSK_DEMOD_SOFT_EN
    ,
    output logic signed [ACC_BITS-1:0] soft_out
`endif
);

    localparam int IDX_BITS = $clog2(DATA_WIDTH + 1);

    state_t                     state_reg, state_next;
    logic                       accept, restart, dump, decided, last_bit;
    logic signed [ACC_BITS-1:0] sum;
    logic [IDX_BITS-1:0]        bit_idx_reg;
    logic [DATA_WIDTH-1:0]      shift_reg, shift_next;
    logic [DATA_WIDTH-1:0]      data_out_reg;
    logic                       bit_out_reg, bit_valid_reg, data_valid_reg;

    assign restart = en && align;
    assign accept  = en && ((state_reg == RUN) || align);

    bpsk_correlator #(
        .SAMPLE_NUMBER(SAMPLE_NUMBER),
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_corr (
        .clk    (clk),
        .srst   (rst),
        .accept (accept),
        .restart(restart),
        .sample (sample),
        .dump   (dump),
        .sum    (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (restart) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_reg == RUN);
    end

    // Non-negative sum decides 1, so an exact tie reads as a 1.
    assign decided    = ~sum[ACC_BITS-1];
    assign shift_next = DATA_WIDTH'({shift_reg, decided});
    assign last_bit   = (bit_idx_reg == IDX_BITS'(DATA_WIDTH - 1));

    // restart and dump never coincide: restart forces phase 0, dump needs the last phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            bit_out_reg    <= 1'b0;
            bit_valid_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
        end else begin
            bit_valid_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
            if (restart) begin
                bit_idx_reg <= '0;
                shift_reg   <= '0;
            end else if (dump) begin
                bit_out_reg   <= decided;
                bit_valid_reg <= 1'b1;
                shift_reg     <= shift_next;
                if (last_bit) begin
                    data_out_reg   <= shift_next;
                    data_valid_reg <= 1'b1;
                    bit_idx_reg    <= '0;
                end else begin
                    bit_idx_reg <= bit_idx_reg + 1'b1;
                end
            end
        end
    end

`ifdef BPSK_DEMOD_SOFT_EN
    logic signed [ACC_BITS-1:0] soft_reg;

    always_ff @(posedge clk) begin
        if (rst)       soft_reg <= '0;
        else if (dump) soft_reg <= sum;
    end

    assign soft_out = soft_reg;
`endif

    assign bit_out    = bit_out_reg;
    assign bit_valid  = bit_valid_reg;
    assign data_out   = data_out_reg;
    assign data_valid = data_valid_reg;

endmodule

// File: tb/tb_bpsk_demod.sv
// Scoreboard bench for bpsk_demod: an ideal modulator drives directed words and a
// monitor checks every bit/word strobe against queued expectations.
module tb_bpsk_demod;
    import bpsk_pkg::*;

    localparam int N  = 256;
    localparam int SW = 12;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          align = 1'b0;
    logic [SW-1:0] sample = 12'd2048;
    logic          bit_out, bit_valid, data_valid, busy;
    logic [DW-1:0] data_out;
`ifdef BPSK_DEMOD_SOFT_EN
    logic signed [ACC_W-1:0] soft_out;
`endif

    always #5 clk = ~clk;

    bpsk_demod #(
        .SAMPLE_NUMBER(N),
        .SAMPLE_WIDTH (SW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sample    (sample),
        .align     (align),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy)
`ifdef BPSK_DEMOD_SOFT_EN
        ,
        .soft_out  (soft_out)
`endif
    );

    int            n_checks = 0;
    int            n_fail = 0;
    bit            bit_q[$];
    logic [DW-1:0] word_q[$];
    longint        soft_q[$];
    longint        dv_times[$];
    longint        cycle = 0;
    logic          en_edge = 1'b0, align_edge = 1'b0, rst_edge = 1'b0;
    int            bits_in_word = 0;
    bit            stall = 1'b0;
    int            noise_amp = 0;
    bit            tie = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cycle);
        end
    endtask

    always @(posedge clk) begin
        cycle      <= cycle + 1;
        en_edge    <= en;
        align_edge <= align;
        rst_edge   <= rst;
    end

    // Monitor: pops the scoreboard whenever the DUT strobes.
    always @(negedge clk) begin
        if (rst_edge || (en_edge && align_edge)) bits_in_word = 0;
        if (bit_valid === 1'b1) begin
            bits_in_word++;
            check("strobe_follows_accepted_sample", longint'(en_edge), 1);
            if (bit_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_bit: bit_valid=1 bit_out=%0d but no bit expected at cycle %0d",
                         bit_out, cycle);
            end else begin
                bit eb;
                longint es;
                eb = bit_q.pop_front();
                es = soft_q.pop_front();
                check("bit_out", longint'(bit_out), longint'(eb));
                $display("bit   cycle %0d: bit_out=%0d expected=%0d soft_model=%0d", cycle, bit_out, eb, es);
`ifdef BPSK_DEMOD_SOFT_EN
                check("soft_out", longint'(soft_out), es);
`endif
            end
        end
        if (data_valid === 1'b1) begin
            dv_times.push_back(cycle);
            if (word_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: data_valid=1 data_out=0x%03h but no word expected at cycle %0d",
                         data_out, cycle);
            end else begin
                logic [DW-1:0] ew;
                ew = word_q.pop_front();
                check("data_out", longint'(data_out), longint'(ew));
                $display("word  cycle %0d: data_out=0x%03h expected=0x%03h", cycle, data_out, ew);
            end
            check("bits_per_word", bits_in_word, DW);
            bits_in_word = 0;
        end
    end

    function automatic logic [SW-1:0] mod_sample(input bit b, input int p);
        real v;
        int  iv;
        if (tie) return 12'd2048;
        v  = 1000.0 * $sin(2.0 * 3.141592653589793 * p / N);
        iv = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        if (!b) iv = -iv;
        if (noise_amp > 0) iv = iv + int'($urandom_range(0, 2 * noise_amp)) - noise_amp;
        return SW'(iv + 2048);
    endfunction

    task automatic put_sample(input logic [SW-1:0] smp, input logic al);
        int gap;
        gap = stall ? int'($urandom_range(0, 5)) : 0;
        repeat (gap) begin
            @(negedge clk);
            en     = 1'b0;
            align  = 1'b0;
            sample = SW'($urandom);
        end
        @(negedge clk);
        en     = 1'b1;
        align  = al;
        sample = smp;
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en    = 1'b0;
            align = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int nbits, input bit al, input bit expect_word);
        for (int i = 0; i < nbits; i++) begin
            bit            b;
            longint        acc;
            logic [SW-1:0] smp;
            b   = w[DW-1-i];
            acc = 0;
            for (int p = 0; p < N; p++) begin
                smp = mod_sample(b, p);
                if (p < N / 2) acc = acc + ob_to_signed(32'(smp), SW);
                else           acc = acc - ob_to_signed(32'(smp), SW);
                put_sample(smp, al && (i == 0) && (p == 0));
            end
            bit_q.push_back(b);
            soft_q.push_back(acc);
        end
        if (expect_word) word_q.push_back(w);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (bit_q.size() != 0 || word_q.size() != 0); k++) @(negedge clk);
        check("pending_bits", bit_q.size(), 0);
        check("pending_words", word_q.size(), 0);
        bit_q.delete();
        word_q.delete();
        soft_q.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_bit_out"}, longint'(bit_out), 0);
        check({tag, "_bit_valid"}, longint'(bit_valid), 0);
        check({tag, "_data_out"}, longint'(data_out), 0);
        check({tag, "_data_valid"}, longint'(data_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
`ifdef BPSK_DEMOD_SOFT_EN
        check({tag, "_soft_out"}, longint'(soft_out), 0);
`endif
    endtask

    initial begin
        repeat (95000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cycle);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        go_idle(2);

        // Loopback: two words back to back, one alignment pulse.
        dv_times.delete();
        send_bits(12'hA5C, DW, 1'b1, 1'b1);
        send_bits(12'h3F1, DW, 1'b0, 1'b1);
        go_idle(3);
        drain();
        if (dv_times.size() >= 2) check("data_valid_spacing", dv_times[1] - dv_times[0], N * DW);
        else                      check("data_valid_count", dv_times.size(), 2);

        // Tie: midscale everywhere decides every bit as 1.
        tie = 1'b1;
        send_bits(12'hFFF, DW, 1'b1, 1'b1);
        tie = 1'b0;
        go_idle(3);
        drain();

        // Stall: random en gaps must not disturb the word.
        stall = 1'b1;
        send_bits(12'h5A5, DW, 1'b1, 1'b1);
        stall = 1'b0;
        go_idle(3);
        drain();

        // Realign at bit 7: partial word dropped, next word decoded cleanly.
        send_bits(12'h0F0, 7, 1'b1, 1'b0);
        for (int p = 0; p < 100; p++) put_sample(mod_sample(1'b1, p), 1'b0);
        send_bits(12'h123, DW, 1'b1, 1'b1);
        go_idle(3);
        drain();

        // Reset at bit 5, then unaligned samples must stay silent.
        send_bits(12'h0F0, 5, 1'b1, 1'b0);
        for (int p = 0; p < 50; p++) put_sample(mod_sample(1'b0, p), 1'b0);
        @(negedge clk);
        rst   = 1'b1;
        en    = 1'b1;
        align = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        en    = 1'b0;
        align = 1'b0;
        check_idle_outputs("midword_reset");
        for (int p = 0; p < 2 * N; p++) put_sample(mod_sample(1'b1, p % N), 1'b0);
        go_idle(3);
        check("no_align_busy", longint'(busy), 0);
        drain();

        // Noise margin: +/-300 LSB uniform noise.
        noise_amp = 300;
        send_bits(12'hC33, DW, 1'b1, 1'b1);
        noise_amp = 0;
        go_idle(3);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
